// File: rtl/shop_cmd_driver.sv
// ----------------------------------------------------------------------------
// shop_cmd_driver
//
// Hardware initiator for the shop command interface. A single compact request
// (LOGIN, LOGOUT or RAW) is expanded into the shop's multi-step ASCII dialogue.
// Each step drives o_shop_a/o_shop_u, pulses o_shop_rdy for one cycle and then
// watches i_shop_a for a change away from the value seen before the strobe.
// The first changed value is captured and checked against the prompt expected
// for that step. The transaction ends with OK, MISMATCH or TIMEOUT, along with
// the failing step index and the last captured response.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_req              request strobe, sampled only while idle
//   i_op               0=LOGIN, 1=LOGOUT, 2/3=RAW
//   i_user, i_pass     LOGIN username / password text
//   i_raw_a, i_raw_u   RAW command text / user index
//   i_shop_a           shop response text
//   o_shop_rdy         one-cycle command strobe to the shop
//   o_shop_u, o_shop_a user index / command text to the shop
//   o_busy             high from request accept until completion
//   o_done             one-cycle completion pulse
//   o_status           0=OK, 1=MISMATCH, 2=TIMEOUT
//   o_fail_step        step index of the failure (0 when OK)
//   o_rsp              last captured response
//
// All ASCII fields are right-aligned, zero-padded string values and are
// compared over their full width.
// ----------------------------------------------------------------------------
module shop_cmd_driver #(
    parameter int unsigned A_NUM_ASCII_CHARS   = 7,
    parameter int unsigned RSP_NUM_ASCII_CHARS = 9,
    parameter int unsigned U_NUM_BITS          = 4,
    parameter int unsigned TIMEOUT_CYCLES      = 64,
    parameter logic [8*A_NUM_ASCII_CHARS-1:0] CMD_LOGIN =
        (8*A_NUM_ASCII_CHARS)'("Login"),
    parameter logic [8*A_NUM_ASCII_CHARS-1:0] CMD_LOGOUT =
        (8*A_NUM_ASCII_CHARS)'("Logout"),
    parameter logic [8*RSP_NUM_ASCII_CHARS-1:0] RSP_USERNAME =
        (8*RSP_NUM_ASCII_CHARS)'("Username?"),
    parameter logic [8*RSP_NUM_ASCII_CHARS-1:0] RSP_PASSWORD =
        (8*RSP_NUM_ASCII_CHARS)'("Password?"),
    parameter logic [8*RSP_NUM_ASCII_CHARS-1:0] RSP_LOGGED_IN =
        (8*RSP_NUM_ASCII_CHARS)'("LoggedIn"),
    parameter logic [8*RSP_NUM_ASCII_CHARS-1:0] RSP_LOGGED_OUT =
        (8*RSP_NUM_ASCII_CHARS)'("LoggedOut")
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_req,
    input  logic [1:0]                       i_op,
    input  logic [8*A_NUM_ASCII_CHARS-1:0]   i_user,
    input  logic [8*A_NUM_ASCII_CHARS-1:0]   i_pass,
    input  logic [8*A_NUM_ASCII_CHARS-1:0]   i_raw_a,
    input  logic [U_NUM_BITS-1:0]            i_raw_u,
    input  logic [8*RSP_NUM_ASCII_CHARS-1:0] i_shop_a,
    output logic                             o_shop_rdy,
    output logic [U_NUM_BITS-1:0]            o_shop_u,
    output logic [8*A_NUM_ASCII_CHARS-1:0]   o_shop_a,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [1:0]                       o_status,
    output logic [1:0]                       o_fail_step,
    output logic [8*RSP_NUM_ASCII_CHARS-1:0] o_rsp
);

    localparam int unsigned A_W = 8 * A_NUM_ASCII_CHARS;
    localparam int unsigned R_W = 8 * RSP_NUM_ASCII_CHARS;
    // One spare bit so TIMEOUT_CYCLES of 1 still gives a legal counter.
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    localparam logic [1:0] OP_LOGIN  = 2'd0;
    localparam logic [1:0] OP_LOGOUT = 2'd1;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_MISMATCH = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StWait,
        StDone
    } state_e;

    state_e                 state_q;
    logic [1:0]             step_q;
    logic [TW-1:0]          timer_q;
    logic [R_W-1:0]         snap_q;

    // Request arguments latched at accept; later steps read only these.
    logic [1:0]             op_q;
    logic [A_W-1:0]         user_q;
    logic [A_W-1:0]         pass_q;
    logic [A_W-1:0]         raw_a_q;
    logic [U_NUM_BITS-1:0]  raw_u_q;

    logic                   shop_rdy_q;
    logic [U_NUM_BITS-1:0]  shop_u_q;
    logic [A_W-1:0]         shop_a_q;
    logic                   busy_q;
    logic                   done_q;
    logic [1:0]             status_q;
    logic [1:0]             fail_step_q;
    logic [R_W-1:0]         rsp_q;

    // Per-step decode of the latched request.
    logic [R_W-1:0]         exp_rsp;
    logic [1:0]             last_step;
    logic                   any_rsp_ok;
    logic                   rsp_changed;
    logic                   rsp_match;

    // Command text for a given op/step. Steps 1 and 2 only exist for LOGIN.
    function automatic logic [A_W-1:0] send_text(
        input logic [1:0]     op,
        input logic [1:0]     step,
        input logic [A_W-1:0] user,
        input logic [A_W-1:0] pass,
        input logic [A_W-1:0] raw_a
    );
        logic [A_W-1:0] txt;
        case (op)
            OP_LOGIN: begin
                case (step)
                    2'd0:    txt = CMD_LOGIN;
                    2'd1:    txt = user;
                    default: txt = pass;
                endcase
            end
            OP_LOGOUT: txt = CMD_LOGOUT;
            default:   txt = raw_a;
        endcase
        return txt;
    endfunction

    function automatic logic [U_NUM_BITS-1:0] send_user(
        input logic [1:0]            op,
        input logic [U_NUM_BITS-1:0] raw_u
    );
        return (op == OP_LOGIN || op == OP_LOGOUT) ? '0 : raw_u;
    endfunction

    always_comb begin
        exp_rsp    = RSP_LOGGED_OUT;
        last_step  = 2'd0;
        any_rsp_ok = 1'b0;
        case (op_q)
            OP_LOGIN: begin
                last_step = 2'd2;
                case (step_q)
                    2'd0:    exp_rsp = RSP_USERNAME;
                    2'd1:    exp_rsp = RSP_PASSWORD;
                    default: exp_rsp = RSP_LOGGED_IN;
                endcase
            end
            OP_LOGOUT: exp_rsp = RSP_LOGGED_OUT;
            default:   any_rsp_ok = 1'b1;
        endcase
        rsp_changed = (i_shop_a != snap_q);
        rsp_match   = any_rsp_ok || (i_shop_a == exp_rsp);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= StIdle;
            step_q      <= 2'd0;
            timer_q     <= '0;
            snap_q      <= '0;
            op_q        <= 2'd0;
            user_q      <= '0;
            pass_q      <= '0;
            raw_a_q     <= '0;
            raw_u_q     <= '0;
            shop_rdy_q  <= 1'b0;
            shop_u_q    <= '0;
            shop_a_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= STATUS_OK;
            fail_step_q <= 2'd0;
            rsp_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req) begin
                        op_q        <= i_op;
                        user_q      <= i_user;
                        pass_q      <= i_pass;
                        raw_a_q     <= i_raw_a;
                        raw_u_q     <= i_raw_u;
                        step_q      <= 2'd0;
                        busy_q      <= 1'b1;
                        status_q    <= STATUS_OK;
                        fail_step_q <= 2'd0;
                        // Step 0 text is registered here so it is already
                        // valid during SETUP, straight from the request inputs.
                        shop_a_q    <= send_text(i_op, 2'd0, i_user, i_pass, i_raw_a);
                        shop_u_q    <= send_user(i_op, i_raw_u);
                        state_q     <= StSetup;
                    end
                end

                StSetup: begin
                    // Baseline for change detection, taken before the strobe.
                    snap_q     <= i_shop_a;
                    shop_rdy_q <= 1'b1;
                    state_q    <= StStrobe;
                end

                StStrobe: begin
                    shop_rdy_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= StWait;
                end

                StWait: begin
                    // A change always takes priority over the timeout.
                    if (rsp_changed) begin
                        rsp_q <= i_shop_a;
                        if (!rsp_match) begin
                            status_q    <= STATUS_MISMATCH;
                            fail_step_q <= step_q;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else if (step_q == last_step) begin
                            status_q    <= STATUS_OK;
                            fail_step_q <= 2'd0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            step_q   <= step_q + 2'd1;
                            shop_a_q <= send_text(op_q, step_q + 2'd1, user_q, pass_q,
                                                  raw_a_q);
                            shop_u_q <= send_user(op_q, raw_u_q);
                            state_q  <= StSetup;
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        status_q    <= STATUS_TIMEOUT;
                        fail_step_q <= step_q;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end

                StDone: begin
                    // Any i_req seen here is dropped; re-accept starts in IDLE.
                    done_q   <= 1'b0;
                    shop_a_q <= '0;
                    shop_u_q <= '0;
                    state_q  <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_shop_rdy  = shop_rdy_q;
    assign o_shop_u    = shop_u_q;
    assign o_shop_a    = shop_a_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_status    = status_q;
    assign o_fail_step = fail_step_q;
    assign o_rsp       = rsp_q;

endmodule

// File: tb/tb_shop_cmd_driver.sv
// ----------------------------------------------------------------------------
// tb_shop_cmd_driver
//
// Drives shop_cmd_driver against a scripted shop responder. Each strobe from
// the driver consumes the next script entry: a delay (0 = never respond) and a
// response value. Expected outcomes come from a step-table model of the
// dialogue, not from the design's state machine.
// ----------------------------------------------------------------------------
module tb_shop_cmd_driver;

    localparam int unsigned AW = 56;
    localparam int unsigned RW = 72;
    localparam int unsigned UW = 4;
    localparam int unsigned TO = 64;

    localparam logic [AW-1:0] S_LOGIN   = 56'("Login");
    localparam logic [AW-1:0] S_LOGOUT  = 56'("Logout");
    localparam logic [RW-1:0] R_USER    = 72'("Username?");
    localparam logic [RW-1:0] R_PASS    = 72'("Password?");
    localparam logic [RW-1:0] R_IN      = 72'("LoggedIn");
    localparam logic [RW-1:0] R_OUT     = 72'("LoggedOut");
    localparam logic [RW-1:0] R_CMDQ    = 72'("Cmd?");

    logic          clk = 1'b0;
    logic          i_reset, i_req;
    logic [1:0]    i_op;
    logic [AW-1:0] i_user, i_pass, i_raw_a;
    logic [UW-1:0] i_raw_u;
    logic [RW-1:0] i_shop_a;
    logic          o_shop_rdy, o_busy, o_done;
    logic [UW-1:0] o_shop_u;
    logic [AW-1:0] o_shop_a;
    logic [1:0]    o_status, o_fail_step;
    logic [RW-1:0] o_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    // Shop responder script and record of every strobe it saw.
    int            scr_dly [8];
    logic [RW-1:0] scr_rsp [8];
    logic [AW-1:0] rec_a   [8];
    logic [UW-1:0] rec_u   [8];
    int            rec_t   [8];
    int            n_rdy    = 0;
    int            shop_cnt = 0;
    logic [RW-1:0] shop_val = '0;
    int            cyc_now  = 0;
    logic [RW-1:0] m_last_rsp = '0;

    always #5 clk = ~clk;

    shop_cmd_driver dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_op        (i_op),
        .i_user      (i_user),
        .i_pass      (i_pass),
        .i_raw_a     (i_raw_a),
        .i_raw_u     (i_raw_u),
        .i_shop_a    (i_shop_a),
        .o_shop_rdy  (o_shop_rdy),
        .o_shop_u    (o_shop_u),
        .o_shop_a    (o_shop_a),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_status    (o_status),
        .o_fail_step (o_fail_step),
        .o_rsp       (o_rsp)
    );

    initial begin
        forever begin
            @(posedge clk);
            cyc_now = cyc_now + 1;
        end
    end

    // Scripted shop: a response with delay d lands d negedges after the strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (shop_cnt > 0) begin
                shop_cnt = shop_cnt - 1;
                if (shop_cnt == 0) i_shop_a = shop_val;
            end
            if (o_shop_rdy && n_rdy < 8) begin
                rec_a[n_rdy] = o_shop_a;
                rec_u[n_rdy] = o_shop_u;
                rec_t[n_rdy] = cyc_now;
                if (scr_dly[n_rdy] != 0) begin
                    shop_cnt = scr_dly[n_rdy];
                    shop_val = scr_rsp[n_rdy];
                end
                n_rdy = n_rdy + 1;
            end
        end
    end

    task automatic set_script(input int d0, input logic [RW-1:0] r0, input int d1,
                              input logic [RW-1:0] r1, input int d2,
                              input logic [RW-1:0] r2);
        for (int i = 0; i < 8; i++) begin
            scr_dly[i] = 4;
            scr_rsp[i] = RW'(i + 1);
        end
        scr_dly[0] = d0; scr_rsp[0] = r0;
        scr_dly[1] = d1; scr_rsp[1] = r1;
        scr_dly[2] = d2; scr_rsp[2] = r2;
    endtask

    // One full transaction, checked against the step-table model.
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] user,
                           input logic [AW-1:0] pass, input logic [AW-1:0] raw_a,
                           input logic [UW-1:0] raw_u, input string name,
                           output int t_rdy0, output int t_done);
        logic [AW-1:0] e_send [3];
        logic [RW-1:0] e_rsp  [3];
        logic [UW-1:0] e_u;
        logic [RW-1:0] cur;
        logic [1:0]    e_stat;
        int            nsteps, e_pulses, e_fstep, cyc;
        logic          raw;

        raw   = (op == 2'd2 || op == 2'd3);
        e_u   = raw ? raw_u : '0;
        e_rsp = '{R_USER, R_PASS, R_IN};
        if (op == 2'd0) begin
            nsteps = 3; e_send = '{S_LOGIN, user, pass};
        end else if (op == 2'd1) begin
            nsteps = 1; e_send = '{S_LOGOUT, '0, '0}; e_rsp[0] = R_OUT;
        end else begin
            nsteps = 1; e_send = '{raw_a, '0, '0};
        end
        cur = i_shop_a; e_stat = 2'd0; e_fstep = 0; e_pulses = 0;
        for (int s = 0; s < nsteps; s++) begin
            e_pulses++;
            if (scr_dly[s] != 0 && scr_dly[s] <= TO && scr_rsp[s] != cur) begin
                cur = scr_rsp[s];
                m_last_rsp = cur;
                if (!raw && cur != e_rsp[s]) begin
                    e_stat = 2'd1; e_fstep = s; break;
                end
            end else begin
                e_stat = 2'd2; e_fstep = s; break;
            end
        end

        n_rdy = 0; shop_cnt = 0;
        @(negedge clk);
        i_req = 1'b1; i_op = op; i_user = user; i_pass = pass;
        i_raw_a = raw_a; i_raw_u = raw_u;
        @(negedge clk);
        i_req = 1'b0;
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s busy_after_accept got=%b want=1", name, o_busy);
        end
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 400) begin
            @(negedge clk); cyc++;
        end
        t_done = cyc_now; t_rdy0 = rec_t[0];
        n_tests++;
        if (o_done !== 1'b1) begin
            n_fail++; $display("FAIL %s done_timeout got=%b want=1", name, o_done);
        end
        n_tests++;
        if (o_status !== e_stat || o_fail_step !== 2'(e_fstep) || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s status/step/busy got=%0d/%0d/%b want=%0d/%0d/0", name,
                     o_status, o_fail_step, o_busy, e_stat, e_fstep);
        end
        n_tests++;
        if (o_rsp !== m_last_rsp) begin
            n_fail++; $display("FAIL %s rsp got=%h want=%h", name, o_rsp, m_last_rsp);
        end
        n_tests++;
        if (n_rdy != e_pulses) begin
            n_fail++; $display("FAIL %s rdy_pulses got=%0d want=%0d", name, n_rdy, e_pulses);
        end
        for (int i = 0; i < e_pulses && i < n_rdy; i++) begin
            n_tests++;
            if (rec_a[i] !== e_send[i] || rec_u[i] !== e_u) begin
                n_fail++;
                $display("FAIL %s sent[%0d] got=%h/%0d want=%h/%0d", name, i, rec_a[i],
                         rec_u[i], e_send[i], e_u);
            end
        end
        @(negedge clk);
        n_tests++;
        if (o_done !== 1'b0 || o_shop_a !== '0 || o_shop_u !== '0 || o_status !== e_stat) begin
            n_fail++;
            $display("FAIL %s idle_after_done got=%b/%h/%0d/%0d want=0/0/0/%0d", name,
                     o_done, o_shop_a, o_shop_u, o_status, e_stat);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_req = 1'b0; i_op = '0; i_user = '0; i_pass = '0;
        i_raw_a = '0; i_raw_u = '0; i_shop_a = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        n_tests++;
        if ({o_shop_rdy, o_shop_u, o_shop_a, o_busy, o_done, o_status, o_fail_step, o_rsp}
            !== '0) begin
            n_fail++; $display("FAIL reset outputs_not_zero got=%h want=0", o_shop_a);
        end
        m_last_rsp = '0;
    endtask

    task automatic test_login();
        int t0, t1;
        set_script(3, R_USER, 3, R_PASS, 3, R_IN);
        run_txn(2'd0, 56'("Adm"), 56'("123"), '0, '0, "login", t0, t1);
    endtask

    task automatic test_mismatch();
        int t0, t1;
        set_script(3, R_USER, 3, R_CMDQ, 3, R_IN);
        run_txn(2'd0, 56'("Uun"), 56'("123"), '0, '0, "mismatch", t0, t1);
    endtask

    task automatic test_timeout();
        int t0, t1;
        set_script(0, '0, 0, '0, 0, '0);
        run_txn(2'd1, '0, '0, '0, '0, "timeout", t0, t1);
        // Done is 1 strobe cycle + TO wait cycles after the strobe cycle.
        n_tests++;
        if (t1 - t0 != TO + 1) begin
            n_fail++; $display("FAIL timeout latency got=%0d want=%0d", t1 - t0, TO + 1);
        end
    endtask

    task automatic test_raw();
        int t0, t1;
        set_script(3, 72'("InvalCmd"), 0, '0, 0, '0);
        run_txn(2'd2, '0, '0, 56'("sdfsdf"), 4'd3, "raw", t0, t1);
    endtask

    task automatic test_timeout_edge();
        int t0, t1;
        set_script(TO, R_OUT, 0, '0, 0, '0);
        run_txn(2'd1, '0, '0, '0, '0, "change_last_cycle", t0, t1);
        set_script(TO + 1, R_CMDQ, 0, '0, 0, '0);
        run_txn(2'd1, '0, '0, '0, '0, "change_after_timeout", t0, t1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, dones, t0, t1;
        set_script(3, R_USER, 40, R_PASS, 3, R_IN);
        n_rdy = 0; shop_cnt = 0;
        @(negedge clk);
        i_req = 1'b1; i_op = 2'd0; i_user = 56'("Adm"); i_pass = 56'("123");
        @(negedge clk);
        i_req = 1'b0;
        cyc = 0;
        while (n_rdy < 2 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0; shop_cnt = 0; i_shop_a = '0; m_last_rsp = '0;
        n_tests++;
        if ({o_shop_rdy, o_shop_u, o_shop_a, o_busy, o_done, o_status, o_fail_step, o_rsp}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs got=busy%b rsp=%h a=%h want=0", o_busy, o_rsp,
                     o_shop_a);
        end
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_busy === 1'b1) dones++;
        end
        n_tests++;
        if (dones != 0) begin
            n_fail++; $display("FAIL reset_mid activity_after_reset got=%0d want=0", dones);
        end
        set_script(2, R_USER, 2, R_PASS, 2, R_IN);
        run_txn(2'd0, 56'("Adm"), 56'("123"), '0, '0, "login_after_reset", t0, t1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        set_script(4, 72'("Rsp0"), 4, 72'("Rsp1"), 4, 72'("Rsp2"));
        n_rdy = 0; shop_cnt = 0;
        @(negedge clk);
        i_req = 1'b1; i_op = 2'd2; i_raw_a = 56'("ping"); i_raw_u = 4'd5;
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (o_done !== 1'b1 || n_rdy != 1) begin
            n_fail++; $display("FAIL hold first_done got=%b/%0d want=1/1", o_done, n_rdy);
        end
        @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL hold done_cycle_req_dropped got=%b want=0", o_busy);
        end
        @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++; $display("FAIL hold reaccept_in_idle got=%b want=1", o_busy);
        end
        i_req = 1'b0;
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (o_done !== 1'b1 || o_status !== 2'd0 || o_rsp !== 72'("Rsp1")) begin
            n_fail++;
            $display("FAIL hold second_done got=%b/%0d/%h want=1/0/Rsp1", o_done, o_status,
                     o_rsp);
        end
        repeat (6) @(negedge clk);
        n_tests++;
        if (o_busy !== 1'b0 || n_rdy != 2) begin
            n_fail++; $display("FAIL hold extra_txn got=%b/%0d want=0/2", o_busy, n_rdy);
        end
        m_last_rsp = 72'("Rsp1");
    endtask

    task automatic test_busy_pulse();
        int cyc;
        set_script(6, R_USER, 6, R_PASS, 6, R_IN);
        n_rdy = 0; shop_cnt = 0; i_shop_a = '0;
        @(negedge clk);
        i_req = 1'b1; i_op = 2'd0; i_user = 56'("Adm"); i_pass = 56'("123");
        @(negedge clk);
        i_req = 1'b0;
        cyc = 0;
        while (n_rdy < 1 && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        i_req = 1'b1; i_op = 2'd2; i_user = 56'("Bad"); i_pass = 56'("Bad");
        @(negedge clk);
        i_req = 1'b0;
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 200) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (o_status !== 2'd0 || n_rdy != 3 || rec_a[1] !== 56'("Adm") ||
            rec_a[2] !== 56'("123") || o_rsp !== R_IN) begin
            n_fail++;
            $display("FAIL busy_pulse args got=%0d/%0d/%h/%h want=0/3/Adm/123", o_status,
                     n_rdy, rec_a[1], rec_a[2]);
        end
        m_last_rsp = R_IN;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int t0, t1, d[3];
        logic [RW-1:0] r[3];
        logic [RW-1:0] good[3];
        logic [1:0] op;
        for (int it = 0; it < 25; it++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0)      good = '{R_USER, R_PASS, R_IN};
            else if (op == 2'd1) good = '{R_OUT, R_OUT, R_OUT};
            else                 good = '{RW'({$urandom(), $urandom()}), R_PASS, R_IN};
            for (int s = 0; s < 3; s++) begin
                case ($urandom_range(0, 19))
                    0:       d[s] = 0;
                    1, 2:    d[s] = TO;
                    3:       d[s] = TO + 1;
                    default: d[s] = $urandom_range(1, 6);
                endcase
                case ($urandom_range(0, 9))
                    0:       r[s] = R_CMDQ;
                    1:       r[s] = i_shop_a;
                    2:       r[s] = R_PASS;
                    default: r[s] = good[s];
                endcase
            end
            set_script(d[0], r[0], d[1], r[1], d[2], r[2]);
            run_txn(op, 56'({$urandom(), $urandom()}), 56'({$urandom(), $urandom()}),
                    56'({$urandom(), $urandom()}), 4'($urandom()), "random", t0, t1);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_login();
        test_mismatch();
        test_timeout();
        test_raw();
        test_timeout_edge();
        test_reset_mid();
        test_back_to_back();
        test_busy_pulse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shop_cmd_driver.md
Name: shop_cmd_driver

Overview:
- Hardware initiator for the shop command interface. It is the counterpart of the shop block's responder side.
- Accepts one compact request (LOGIN, LOGOUT or RAW command) and expands it into the shop's multi-step ASCII dialogue.
- For each step it drives a/u/rdy, then watches the shop's ASCII response for the expected prompt.
- Reports OK, MISMATCH or TIMEOUT, plus the failing step and the last response. Replaces hand-sequenced benches and serves as a front-end for a scripted on-board exerciser.

Parameters:
- A_NUM_ASCII_CHARS, 7, width of the command/argument to the shop in chars (A_BITS = 8x).
- RSP_NUM_ASCII_CHARS, 9, width of the shop response in chars (R_BITS = 8x).
- U_NUM_BITS, 4, width of the user-index field.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT for a response change.
- CMD_LOGIN, "Login", command text for a login.
- CMD_LOGOUT, "Logout", command text for a logout.
- RSP_USERNAME, "Username?", expected response to the login command.
- RSP_PASSWORD, "Password?", expected response to the username.
- RSP_LOGGED_IN, "LoggedIn", expected response to the password.
- RSP_LOGGED_OUT, "LoggedOut", expected response to the logout command.

Ports:
- i_clk in 1: clock.
- i_reset in 1: synchronous active-high reset.
- i_req in 1: request strobe; sampled only in IDLE.
- i_op in 2: 0=LOGIN, 1=LOGOUT, 2=RAW, 3=reserved (treated as RAW).
- i_user in A_BITS: username for LOGIN.
- i_pass in A_BITS: password for LOGIN.
- i_raw_a in A_BITS: command text for RAW.
- i_raw_u in U_NUM_BITS: user index for RAW.
- i_shop_a in R_BITS: shop response (shop o_a).
- o_shop_rdy out 1: to shop i_rdy.
- o_shop_u out U_NUM_BITS: to shop i_u.
- o_shop_a out A_BITS: to shop i_a.
- o_busy out 1: high from request accept until o_done.
- o_done out 1: one-cycle completion pulse.
- o_status out 2: 0=OK, 1=MISMATCH, 2=TIMEOUT.
- o_fail_step out 2: step index at failure (0 when OK).
- o_rsp out R_BITS: last captured response.

Behaviour:
- All outputs registered. Reset (sync, high) forces state IDLE and zeroes every output, step counter, timer and snapshot. Reset mid-transaction aborts it; no o_done is produced.
- ASCII values are Verilog string literals, right-aligned and zero-padded to port width. All comparisons are full-width equality.
- States: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE:
  - On i_req=1, latch i_op/i_user/i_pass/i_raw_a/i_raw_u.
  - Set step=0, o_busy=1, go to SETUP.
  - i_req is ignored in every other state.
- SETUP (1 cycle):
  - o_shop_a/o_shop_u are driven for the current step and stay stable through STROBE and WAIT.
  - i_shop_a is copied into the snapshot on exit.
- STROBE (1 cycle): o_shop_rdy=1. It is low in every other state.
- WAIT:
  - Timer counts from 0. "Change" means i_shop_a != snapshot.
  - On the first change cycle: o_rsp <= i_shop_a, then compare against the step's expectation.
  - Match → if last step, go to DONE with OK; else step+1 and go to SETUP.
  - Non-match → go to DONE with MISMATCH and o_fail_step=step.
  - Timer reaching TIMEOUT_CYCLES-1 with no change → go to DONE with TIMEOUT and o_fail_step=step. o_rsp is unchanged.
  - Change and timeout in the same cycle: change wins.
- Step tables (o_shop_u = 0 except for RAW):
  - LOGIN step 0: send CMD_LOGIN, expect RSP_USERNAME.
  - LOGIN step 1: send i_user, expect RSP_PASSWORD.
  - LOGIN step 2: send i_pass, expect RSP_LOGGED_IN.
  - LOGOUT step 0: send CMD_LOGOUT, expect RSP_LOGGED_OUT.
  - RAW step 0: send i_raw_a with i_raw_u; any change is a match.
- DONE (1 cycle):
  - o_done=1, o_busy=0, then IDLE.
  - o_status/o_fail_step/o_rsp hold until the next accepted request.
  - o_shop_a/o_shop_u return to 0 in IDLE.
- Latency per step = 2 + (cycles from rdy to response change). An i_req in the DONE cycle is dropped. The earliest re-accept is the first IDLE cycle.

Test Plan:
- LOGIN, user="Adm", pass="123", model shop responds 3 cycles after each rdy with Username?/Password?/LoggedIn:
  - Expect exactly three o_shop_rdy pulses carrying o_shop_a = "Login", "Adm", "123".
  - Expect o_done with status 0 and o_rsp="LoggedIn".
- LOGIN with unknown user "Uun", model returns "Cmd?" at step 1 → status 1, o_fail_step=1, o_rsp="Cmd?", only two rdy pulses.
- LOGOUT, model never changes i_shop_a → o_done exactly TIMEOUT_CYCLES cycles after WAIT entry, status 2, o_fail_step=0.
- RAW i_raw_a="sdfsdf", i_raw_u=4'd3, model returns "InvalCmd" → o_shop_u=3 during STROBE, status 0, o_rsp="InvalCmd".
- Assert i_reset during LOGIN step 1 WAIT → next cycle all outputs 0, no o_done. A following LOGIN completes normally.
- i_req held high across a whole transaction → exactly one transaction per IDLE entry. A pulse while busy changes no latched argument.
